// File: rtl/multi_stair_engine.sv
`default_nettype none
// ============================================================================
// Module   : multi_stair_engine
// Purpose  : Draws, erases and moves a set of stairs upward with wrap-around,
//            emitting one pixel write per cycle during each scan.
// Revision : 1.0 - initial release
// ============================================================================
module multi_stair_engine #(
    parameter int          NUM_STAIRS      = 3,
    parameter int          STAIR_W         = 40,
    parameter int          STAIR_H         = 5,
    parameter int          FRAME_DELAY     = 833334,
    parameter int          FRAMES_PER_STEP = 4,
    parameter int          STEP            = 1,
    parameter int          WRAP_Y          = 116,
    parameter logic [2:0]  COLOUR          = 3'b100
)(
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      go,
    input  logic                      stop,
    input  logic [8*NUM_STAIRS-1:0]   init_x,
    input  logic [7*NUM_STAIRS-1:0]   init_y,
    output logic [7:0]                x,
    output logic [6:0]                y,
    output logic [2:0]                colour,
    output logic                      plot,
    output logic                      busy,
    output logic [2:0]                current_state
);

    localparam logic [2:0]  c_IDLE       = 3'd0;
    localparam logic [2:0]  c_START_WAIT = 3'd1;
    localparam logic [2:0]  c_DRAW       = 3'd2;
    localparam logic [2:0]  c_WAIT       = 3'd3;
    localparam logic [2:0]  c_ERASE      = 3'd4;
    localparam logic [2:0]  c_MOVE       = 3'd5;

    localparam logic [2:0]  c_K_LAST      = 3'(NUM_STAIRS - 1);
    localparam logic [6:0]  c_R_LAST      = 7'(STAIR_H - 1);
    localparam logic [7:0]  c_C_LAST      = 8'(STAIR_W - 1);
    localparam logic [31:0] c_DELAY_LAST  = 32'(FRAME_DELAY - 1);
    localparam logic [31:0] c_FRAMES_LAST = 32'(FRAMES_PER_STEP - 1);
    localparam logic [6:0]  c_STEP        = 7'(STEP);
    localparam logic [6:0]  c_WRAP_Y      = 7'(WRAP_Y);

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [2:0]  r_k;
    logic [6:0]  r_r;
    logic [7:0]  r_c;
    logic [31:0] r_delay_cnt;
    logic [31:0] r_frame_cnt;

    logic w_scanning;
    logic w_scan_last;
    logic w_frame_tick;
    logic w_step_due;
    logic w_load;
    logic w_move;

    logic [8*NUM_STAIRS-1:0] w_sx_all;
    logic [7*NUM_STAIRS-1:0] w_sy_all;
    logic [7:0]              w_sel_x;
    logic [6:0]              w_sel_y;

    assign w_scanning   = (r_state == c_DRAW) || (r_state == c_ERASE);
    assign w_scan_last  = w_scanning && (r_k == c_K_LAST) && (r_r == c_R_LAST) && (r_c == c_C_LAST);
    assign w_frame_tick = (r_state == c_WAIT) && (r_delay_cnt == c_DELAY_LAST);
    assign w_step_due   = w_frame_tick && (r_frame_cnt == c_FRAMES_LAST);
    assign w_load       = (r_state == c_IDLE) && go;
    assign w_move       = (r_state == c_MOVE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:       if (go)          w_next = c_START_WAIT;
            c_START_WAIT: if (!go)         w_next = c_DRAW;
            c_DRAW:       if (w_scan_last) w_next = c_WAIT;
            c_WAIT:       if (w_step_due)  w_next = c_ERASE;
            c_ERASE:      if (w_scan_last) w_next = c_MOVE;
            c_MOVE:       w_next = stop ? c_IDLE : c_DRAW;
            default:      w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= c_IDLE;
        else          r_state <= w_next;
    end

    // Counters sit at zero outside a scan, so every scan entry starts clean.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_k <= '0;
            r_r <= '0;
            r_c <= '0;
        end else if (!w_scanning || w_scan_last) begin
            r_k <= '0;
            r_r <= '0;
            r_c <= '0;
        end else if (r_c == c_C_LAST) begin
            r_c <= '0;
            if (r_r == c_R_LAST) begin
                r_r <= '0;
                r_k <= r_k + 3'd1;
            end else begin
                r_r <= r_r + 7'd1;
            end
        end else begin
            r_c <= r_c + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_delay_cnt <= '0;
            r_frame_cnt <= '0;
        end else if (r_state != c_WAIT) begin
            r_delay_cnt <= '0;
            r_frame_cnt <= '0;
        end else if (w_frame_tick) begin
            r_delay_cnt <= '0;
            r_frame_cnt <= r_frame_cnt + 32'd1;
        end else begin
            r_delay_cnt <= r_delay_cnt + 32'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAIRS; gi++) begin : g_stair
            logic [7:0] r_sx;
            logic [6:0] r_sy;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_sx <= '0;
                    r_sy <= '0;
                end else if (w_load) begin
                    r_sx <= init_x[8*gi +: 8];
                    r_sy <= init_y[7*gi +: 7];
                end else if (w_move) begin
                    r_sy <= (r_sy < c_STEP) ? c_WRAP_Y : (r_sy - c_STEP);
                end
            end

            assign w_sx_all[8*gi +: 8] = r_sx;
            assign w_sy_all[7*gi +: 7] = r_sy;
        end
    endgenerate

    always_comb begin
        w_sel_x = '0;
        w_sel_y = '0;
        for (int i = 0; i < NUM_STAIRS; i++) begin
            if (r_k == 3'(i)) begin
                w_sel_x = w_sx_all[8*i +: 8];
                w_sel_y = w_sy_all[7*i +: 7];
            end
        end
    end

    // Coordinate sums wrap naturally at the 8-bit and 7-bit output widths.
    assign plot          = w_scanning;
    assign x             = w_scanning ? (w_sel_x + r_c) : 8'd0;
    assign y             = w_scanning ? (w_sel_y + r_r) : 7'd0;
    assign colour        = (r_state == c_DRAW) ? COLOUR : 3'b000;
    assign busy          = (r_state != c_IDLE);
    assign current_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multi_stair_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_stair_engine
// Purpose  : Self-checking bench comparing the engine against a pixel-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_stair_engine;

    localparam int NS  = 2;
    localparam int SW  = 4;
    localparam int SH  = 2;
    localparam int FD  = 3;
    localparam int FPS = 2;
    localparam int ST  = 1;
    localparam int WY  = 116;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          go;
    logic          stop;
    logic [15:0]   init_x;
    logic [13:0]   init_y;
    logic [7:0]    x;
    logic [6:0]    y;
    logic [2:0]    colour;
    logic          plot;
    logic          busy;
    logic [2:0]    current_state;

    int n_tests = 0;
    int n_fail  = 0;
    int mx [NS];
    int my [NS];

    multi_stair_engine #(
        .NUM_STAIRS(NS), .STAIR_W(SW), .STAIR_H(SH), .FRAME_DELAY(FD),
        .FRAMES_PER_STEP(FPS), .STEP(ST), .WRAP_Y(WY), .COLOUR(3'b100)
    ) dut (
        .clock(clock), .reset_n(reset_n), .go(go), .stop(stop),
        .init_x(init_x), .init_y(init_y), .x(x), .y(y), .colour(colour),
        .plot(plot), .busy(busy), .current_state(current_state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_state"}, 32'(current_state), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_plot"},  32'(plot), 0);
        chk({tag, "_xy"},    {17'd0, x, y}, 0);
        chk({tag, "_col"},   32'(colour), 0);
    endtask

    task automatic start_run(input int x0, input int y0, input int x1, input int y1, input int hold);
        init_x = {8'(x1), 8'(x0)};
        init_y = {7'(y1), 7'(y0)};
        go = 1'b1;
        step();
        mx[0] = x0; my[0] = y0;
        mx[1] = x1; my[1] = y1;
        for (int h = 0; h < hold; h++) begin
            chk("sw_state", 32'(current_state), 1);
            chk("sw_plot", 32'(plot), 0);
            chk("sw_busy", 32'(busy), 1);
            init_x = 16'($urandom);
            init_y = 14'($urandom);
            step();
        end
        go = 1'b0;
        chk("sw_release_state", 32'(current_state), 1);
        step();
    endtask

    task automatic scan(input int col);
        for (int k = 0; k < NS; k++)
            for (int r = 0; r < SH; r++)
                for (int c = 0; c < SW; c++) begin
                    chk(col != 0 ? "draw_state" : "erase_state", 32'(current_state), col != 0 ? 2 : 4);
                    chk("scan_plot", 32'(plot), 1);
                    chk("scan_x", 32'(x), (mx[k] + c) % 256);
                    chk("scan_y", 32'(y), (my[k] + r) % 128);
                    chk("scan_colour", 32'(colour), col);
                    go   = 1'($urandom);
                    stop = 1'($urandom);
                    init_x = 16'($urandom);
                    step();
                end
        go = 1'b0;
    endtask

    task automatic wait_phase();
        for (int i = 0; i < FD * FPS; i++) begin
            chk("wait_state", 32'(current_state), 3);
            chk("wait_plot", 32'(plot), 0);
            chk("wait_busy", 32'(busy), 1);
            go = 1'($urandom);
            step();
        end
        go = 1'b0;
    endtask

    task automatic move_phase(input bit s);
        chk("move_state", 32'(current_state), 5);
        chk("move_plot", 32'(plot), 0);
        chk("move_busy", 32'(busy), 1);
        stop = s;
        go   = 1'b0;
        step();
        stop = 1'b0;
        for (int k = 0; k < NS; k++)
            my[k] = (my[k] < ST) ? WY : my[k] - ST;
        if (s) begin
            for (int i = 0; i < 3; i++) begin
                chk_idle("stopped");
                step();
            end
        end
    endtask

    task automatic frame_cycle(input bit s);
        scan(3'b100);
        wait_phase();
        scan(0);
        move_phase(s);
    endtask

    initial begin
        reset_n = 1'b0;
        go      = 1'b0;
        stop    = 1'b0;
        init_x  = '0;
        init_y  = '0;
        #12;
        chk_idle("reset");
        @(negedge clock);
        reset_n = 1'b1;
        step();
        chk_idle("post_reset");

        // Reference case: two stairs at (60,40) and (100,10)
        start_run(60, 40, 100, 10, 1);
        frame_cycle(1'b0);
        frame_cycle(1'b1);

        // Top wrap on y and right wrap on x
        start_run(254, 0, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), 2);
        frame_cycle(1'b0);
        frame_cycle(1'b1);

        for (int run = 0; run < 4; run++) begin
            int nf;
            nf = int'($urandom_range(1, 3));
            start_run(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                      int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                      int'($urandom_range(1, 4)));
            for (int f = 0; f < nf; f++)
                frame_cycle(f == nf - 1);
        end

        // Asynchronous reset in the middle of a draw scan
        start_run(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), 1);
        for (int i = 0; i < 5; i++) begin
            chk("pre_rst_plot", 32'(plot), 1);
            step();
        end
        #2 reset_n = 1'b0;
        #1 chk_idle("async_rst");
        @(posedge clock);
        #1 chk("rst_hold_state", 32'(current_state), 0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_idle("after_rst");
        end

        start_run(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), 1);
        frame_cycle(1'b0);
        frame_cycle(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
